// File: rtl/kdf_core_arbiter.sv
// kdf_core_arbiter: two-requester round-robin front end for one KDF core.
// Ports: clk/rst (sync, active high); req_i, salt/count/pwd{0,1}_i from
// requesters; gnt_o/done_o one-hot pulses, key_o/timeout_o job result,
// busy_o; core_rst_o/core_salt_o/core_count_o/core_pwd_o drive the core,
// core_key_i/core_end_i come back from it.
module kdf_core_arbiter #(
    parameter int SALT_W  = 64,
    parameter int COUNT_W = 32,
    parameter int PWD_W   = 32,
    parameter int KEY_W   = 128,
    parameter int TIMEOUT = 1 << 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_i,
    input  logic [SALT_W-1:0]  salt0_i,
    input  logic [SALT_W-1:0]  salt1_i,
    input  logic [COUNT_W-1:0] count0_i,
    input  logic [COUNT_W-1:0] count1_i,
    input  logic [PWD_W-1:0]   pwd0_i,
    input  logic [PWD_W-1:0]   pwd1_i,
    output logic [1:0]         gnt_o,
    output logic [1:0]         done_o,
    output logic [KEY_W-1:0]   key_o,
    output logic               timeout_o,
    output logic               busy_o,
    output logic               core_rst_o,
    output logic [SALT_W-1:0]  core_salt_o,
    output logic [COUNT_W-1:0] core_count_o,
    output logic [PWD_W-1:0]   core_pwd_o,
    input  logic [KEY_W-1:0]   core_key_i,
    input  logic               core_end_i
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_last;
    logic               r_sel;
    logic [WD_W-1:0]    r_wdog;
    logic [1:0]         r_gnt;
    logic [1:0]         r_done;
    logic [KEY_W-1:0]   r_key;
    logic               r_tmo;
    logic               r_busy;
    logic               r_core_rst;
    logic [SALT_W-1:0]  r_salt;
    logic [COUNT_W-1:0] r_count;
    logic [PWD_W-1:0]   r_pwd;

    logic [1:0]         w_elig;
    logic               w_pick;
    logic               w_hit;
    logic               w_finish;

    // A requester in its own done cycle is not eligible, so a held
    // request lets the other side in first.
    assign w_elig   = req_i & ~r_done;
    // Watchdog counts elapsed RUN cycles; the job is abandoned once
    // TIMEOUT of them have passed without an end.
    assign w_hit    = (r_wdog == WD_LIMIT);
    assign w_finish = core_end_i | w_hit;

    always_comb begin
        w_pick = 1'b0;
        if (&w_elig) begin
            w_pick = ~r_last;
        end else begin
            w_pick = w_elig[1];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: if (|w_elig) w_state_nxt = S_LOAD;
            S_LOAD: w_state_nxt = S_RUN;
            S_RUN:  if (w_finish) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_sel      <= 1'b0;
            r_wdog     <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_key      <= '0;
            r_tmo      <= 1'b0;
            r_busy     <= 1'b0;
            r_core_rst <= 1'b1;
            r_salt     <= '0;
            r_count    <= '0;
            r_pwd      <= '0;
        end else begin
            r_gnt  <= '0;
            r_done <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (|w_elig) begin
                        r_sel   <= w_pick;
                        r_gnt   <= w_pick ? 2'b10 : 2'b01;
                        r_busy  <= 1'b1;
                        r_salt  <= w_pick ? salt1_i : salt0_i;
                        r_count <= w_pick ? count1_i : count0_i;
                        r_pwd   <= w_pick ? pwd1_i : pwd0_i;
                    end
                end
                S_LOAD: begin
                    r_core_rst <= 1'b0;
                    r_wdog     <= '0;
                end
                S_RUN: begin
                    r_wdog <= r_wdog + WD_W'(1);
                    if (w_finish) begin
                        // End beats a coincident timeout.
                        r_key      <= core_end_i ? core_key_i : '0;
                        r_tmo      <= ~core_end_i;
                        r_done     <= r_sel ? 2'b10 : 2'b01;
                        r_last     <= r_sel;
                        r_busy     <= 1'b0;
                        r_core_rst <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt_o        = r_gnt;
    assign done_o       = r_done;
    assign key_o        = r_key;
    assign timeout_o    = r_tmo;
    assign busy_o       = r_busy;
    assign core_rst_o   = r_core_rst;
    assign core_salt_o  = r_salt;
    assign core_count_o = r_count;
    assign core_pwd_o   = r_pwd;

endmodule

// File: tb/tb_kdf_core_arbiter.sv
// tb_kdf_core_arbiter: directed bench for kdf_core_arbiter with a
// behavioural core that raises end a set number of cycles after release.
module tb_kdf_core_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   req_i = 2'b00;
    logic [63:0]  salt0_i = '0, salt1_i = '0;
    logic [31:0]  count0_i = '0, count1_i = '0;
    logic [31:0]  pwd0_i = '0, pwd1_i = '0;
    logic [1:0]   gnt_o, done_o;
    logic [127:0] key_o;
    logic         timeout_o, busy_o, core_rst_o;
    logic [63:0]  core_salt_o;
    logic [31:0]  core_count_o, core_pwd_o;
    logic [127:0] core_key_i = '0;
    logic         core_end_i;

    int vecs = 0;
    int miss = 0;

    // core model: cycles since reset release, end when it reaches end_dly
    int cnt = 0;
    int end_dly = 1000;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (core_rst_o) cnt <= 0;
        else cnt <= cnt + 1;
    end

    assign core_end_i = !core_rst_o && (cnt == end_dly);

    kdf_core_arbiter #(
        .SALT_W(64), .COUNT_W(32), .PWD_W(32), .KEY_W(128), .TIMEOUT(64)
    ) dut (
        .clk(clk), .rst(rst), .req_i(req_i),
        .salt0_i(salt0_i), .salt1_i(salt1_i),
        .count0_i(count0_i), .count1_i(count1_i),
        .pwd0_i(pwd0_i), .pwd1_i(pwd1_i),
        .gnt_o(gnt_o), .done_o(done_o), .key_o(key_o),
        .timeout_o(timeout_o), .busy_o(busy_o),
        .core_rst_o(core_rst_o), .core_salt_o(core_salt_o),
        .core_count_o(core_count_o), .core_pwd_o(core_pwd_o),
        .core_key_i(core_key_i), .core_end_i(core_end_i)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output int n, input string tag);
        n = 0;
        do begin
            step();
            n++;
        end while (gnt_o == 2'b00 && n < 50);
        if (gnt_o == 2'b00) begin
            vecs++; miss++;
            $display("FAIL %s_gnt_wait no grant after %0d cycles", tag, n);
        end
    endtask

    task automatic wait_done(output int n, input string tag);
        n = 0;
        do begin
            step();
            n++;
        end while (done_o == 2'b00 && n < 200);
        if (done_o == 2'b00) begin
            vecs++; miss++;
            $display("FAIL %s_done_wait no done after %0d cycles", tag, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        vecs++;
        if (gnt_o !== 2'b00 || done_o !== 2'b00) begin
            miss++;
            $display("FAIL rst_pulses got gnt=%b done=%b want 00/00", gnt_o, done_o);
        end
        vecs++;
        if (busy_o !== 1'b0 || timeout_o !== 1'b0 || core_rst_o !== 1'b1) begin
            miss++;
            $display("FAIL rst_flags got busy=%b tmo=%b crst=%b want 0/0/1",
                     busy_o, timeout_o, core_rst_o);
        end
        vecs++;
        if (key_o !== '0 || core_salt_o !== '0 || core_count_o !== '0 || core_pwd_o !== '0) begin
            miss++;
            $display("FAIL rst_data got key=%h salt=%h cnt=%h pwd=%h want all 0",
                     key_o, core_salt_o, core_count_o, core_pwd_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        salt0_i = 64'h0011223344556677;
        count0_i = 32'd4;
        pwd0_i = 32'hCAFEBABE;
        core_key_i = 128'h000102030405060708090A0B0C0D0E0F;
        end_dly = 10;
        req_i = 2'b01;
        step();
        vecs++;
        if (gnt_o !== 2'b01 || busy_o !== 1'b1 || core_rst_o !== 1'b1) begin
            miss++;
            $display("FAIL single_t1 got gnt=%b busy=%b crst=%b want 01/1/1",
                     gnt_o, busy_o, core_rst_o);
        end
        vecs++;
        if (core_salt_o !== 64'h0011223344556677 || core_count_o !== 32'd4 ||
            core_pwd_o !== 32'hCAFEBABE) begin
            miss++;
            $display("FAIL single_ops got %h/%h/%h want 0011223344556677/4/cafebabe",
                     core_salt_o, core_count_o, core_pwd_o);
        end
        req_i = 2'b00;
        salt0_i = '1;
        step();
        vecs++;
        if (core_rst_o !== 1'b0 || gnt_o !== 2'b00) begin
            miss++;
            $display("FAIL single_t2 got crst=%b gnt=%b want 0/00", core_rst_o, gnt_o);
        end
        repeat (10) step();
        vecs++;
        if (done_o !== 2'b00) begin
            miss++;
            $display("FAIL single_t12 got done=%b want 00", done_o);
        end
        step();
        vecs++;
        if (done_o !== 2'b01 || timeout_o !== 1'b0 ||
            key_o !== 128'h000102030405060708090A0B0C0D0E0F) begin
            miss++;
            $display("FAIL single_t13 got done=%b tmo=%b key=%h want 01/0/000102..0f",
                     done_o, timeout_o, key_o);
        end
        vecs++;
        if (core_rst_o !== 1'b1 || busy_o !== 1'b0 || core_salt_o !== 64'h0011223344556677) begin
            miss++;
            $display("FAIL single_idle got crst=%b busy=%b salt=%h want 1/0/0011223344556677",
                     core_rst_o, busy_o, core_salt_o);
        end
        step();
    endtask

    task automatic test_tie();
        int n;
        do_reset();
        salt0_i = 64'hA0A0A0A0A0A0A0A0; count0_i = 32'd7; pwd0_i = 32'h11110000;
        salt1_i = 64'hB1B1B1B1B1B1B1B1; count1_i = 32'd9; pwd1_i = 32'h22221111;
        core_key_i = 128'h5555;
        end_dly = 3;
        req_i = 2'b11;
        step();
        vecs++;
        if (gnt_o !== 2'b01 || core_salt_o !== 64'hA0A0A0A0A0A0A0A0) begin
            miss++;
            $display("FAIL tie_first got gnt=%b salt=%h want 01/a0a0a0a0a0a0a0a0",
                     gnt_o, core_salt_o);
        end
        wait_done(n, "tie0");
        vecs++;
        if (done_o !== 2'b01) begin
            miss++;
            $display("FAIL tie_done0 got %b want 01", done_o);
        end
        step();
        vecs++;
        if (gnt_o !== 2'b10 || core_salt_o !== 64'hB1B1B1B1B1B1B1B1 ||
            core_count_o !== 32'd9 || core_pwd_o !== 32'h22221111) begin
            miss++;
            $display("FAIL tie_second got gnt=%b ops=%h/%h/%h want 10/b1b1b1b1b1b1b1b1/9/22221111",
                     gnt_o, core_salt_o, core_count_o, core_pwd_o);
        end
        wait_done(n, "tie1");
        vecs++;
        if (done_o !== 2'b10) begin
            miss++;
            $display("FAIL tie_done1 got %b want 10", done_o);
        end
        req_i = 2'b00;
        repeat (2) step();
    endtask

    task automatic test_fairness();
        int n;
        logic [1:0] g;
        logic [1:0] exp_g;
        end_dly = 2;
        req_i = 2'b11;
        for (int j = 0; j < 4; j++) begin
            exp_g = (j % 2 == 0) ? 2'b01 : 2'b10;
            wait_gnt(n, "fair");
            g = gnt_o;
            vecs++;
            if (g !== exp_g) begin
                miss++;
                $display("FAIL fair_gnt%0d got %b want %b", j, g, exp_g);
            end
            wait_done(n, "fair");
            vecs++;
            if (done_o !== exp_g) begin
                miss++;
                $display("FAIL fair_done%0d got %b want %b", j, done_o, exp_g);
            end
        end
        req_i = 2'b00;
        repeat (2) step();
    endtask

    task automatic test_timeout();
        int n;
        end_dly = 1000;
        core_key_i = 128'hDEAD;
        req_i = 2'b01;
        wait_gnt(n, "tmo");
        req_i = 2'b00;
        step();
        vecs++;
        if (core_rst_o !== 1'b0) begin
            miss++;
            $display("FAIL tmo_fall got crst=%b want 0", core_rst_o);
        end
        wait_done(n, "tmo");
        vecs++;
        if (n != 65) begin
            miss++;
            $display("FAIL tmo_latency got %0d cycles want 65", n);
        end
        vecs++;
        if (done_o !== 2'b01 || timeout_o !== 1'b1 || key_o !== '0) begin
            miss++;
            $display("FAIL tmo_result got done=%b tmo=%b key=%h want 01/1/0",
                     done_o, timeout_o, key_o);
        end
        end_dly = 5;
        core_key_i = 128'h0123456789ABCDEF_FEDCBA9876543210;
        req_i = 2'b10;
        wait_gnt(n, "tmo_next");
        req_i = 2'b00;
        vecs++;
        if (gnt_o !== 2'b10) begin
            miss++;
            $display("FAIL tmo_next_gnt got %b want 10", gnt_o);
        end
        wait_done(n, "tmo_next");
        vecs++;
        if (done_o !== 2'b10 || timeout_o !== 1'b0 ||
            key_o !== 128'h0123456789ABCDEF_FEDCBA9876543210) begin
            miss++;
            $display("FAIL tmo_next_done got done=%b tmo=%b key=%h want 10/0/0123456789abcdeffedcba9876543210",
                     done_o, timeout_o, key_o);
        end
        step();
    endtask

    task automatic test_end_and_timeout();
        int n;
        end_dly = 64;
        core_key_i = 128'hFACE_0000_0000_0000_0000_0000_0000_BEEF;
        req_i = 2'b01;
        wait_gnt(n, "both");
        req_i = 2'b00;
        step();
        wait_done(n, "both");
        vecs++;
        if (n != 65) begin
            miss++;
            $display("FAIL both_latency got %0d cycles want 65", n);
        end
        vecs++;
        if (timeout_o !== 1'b0 || key_o !== 128'hFACE_0000_0000_0000_0000_0000_0000_BEEF) begin
            miss++;
            $display("FAIL both_result got tmo=%b key=%h want 0/face..beef", timeout_o, key_o);
        end
        step();
    endtask

    task automatic test_reset_mid_run();
        int n;
        end_dly = 1000;
        req_i = 2'b01;
        wait_gnt(n, "mid");
        req_i = 2'b00;
        step();
        repeat (5) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        vecs++;
        if (core_rst_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 2'b00 || gnt_o !== 2'b00) begin
            miss++;
            $display("FAIL mid_reset got crst=%b busy=%b done=%b gnt=%b want 1/0/00/00",
                     core_rst_o, busy_o, done_o, gnt_o);
        end
        repeat (3) step();
        vecs++;
        if (done_o !== 2'b00 || busy_o !== 1'b0) begin
            miss++;
            $display("FAIL mid_quiet got done=%b busy=%b want 00/0", done_o, busy_o);
        end
        end_dly = 4;
        core_key_i = 128'h77;
        salt1_i = 64'h1234;
        req_i = 2'b10;
        wait_gnt(n, "mid_next");
        req_i = 2'b00;
        vecs++;
        if (gnt_o !== 2'b10 || core_salt_o !== 64'h1234) begin
            miss++;
            $display("FAIL mid_next_gnt got gnt=%b salt=%h want 10/1234", gnt_o, core_salt_o);
        end
        wait_done(n, "mid_next");
        vecs++;
        if (done_o !== 2'b10 || key_o !== 128'h77 || timeout_o !== 1'b0) begin
            miss++;
            $display("FAIL mid_next_done got done=%b key=%h tmo=%b want 10/77/0",
                     done_o, key_o, timeout_o);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_tie();
        test_fairness();
        test_timeout();
        test_end_and_timeout();
        test_reset_mid_run();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
